// File: rtl/alu_arb_if.sv
// Request/response channels between the two ALU requesters and alu_arbiter.
// Requesters use the master modport; the arbiter uses the slave modport.
interface alu_arb_if #(
  parameter int n = 32
);
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [3:0]   req_sel0;
  logic [3:0]   req_sel1;
  logic [n-1:0] req_a0;
  logic [n-1:0] req_a1;
  logic [n-1:0] req_b0;
  logic [n-1:0] req_b1;
  logic [1:0]   rsp_valid;
  logic [1:0]   rsp_ready;
  logic [n-1:0] rsp_data;
  logic [3:0]   rsp_flags;

  modport master (
    output req_valid, req_sel0, req_sel1, req_a0, req_a1, req_b0, req_b1, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_flags
  );

  modport slave (
    input  req_valid, req_sel0, req_sel1, req_a0, req_a1, req_b0, req_b1, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_flags
  );
endinterface

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters (round-robin by default).
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins ties, port 1 may starve).
//
//   state  | meaning
//   IDLE   | pick a winner, accept its request, latch opcode/operands
//   EXEC   | latched operands drive the ALU; result captured at end of cycle
//   RESP   | result held on owner's response channel until owner accepts
module alu_arbiter #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         rst,
  alu_arb_if.slave     bus,
  output logic [3:0]   alu_sel,
  output logic [n-1:0] alu_a,
  output logic [n-1:0] alu_b,
  input  logic [n-1:0] alu_out,
  input  logic         alu_cf,
  input  logic         alu_zf,
  input  logic         alu_vf,
  input  logic         alu_sf
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t       state_q, state_d;
  logic         owner_q, owner_d;
  logic [3:0]   sel_q, sel_d;
  logic [n-1:0] a_q, a_d;
  logic [n-1:0] b_q, b_d;
  logic [n-1:0] data_q, data_d;
  logic [3:0]   flags_q, flags_d;
  logic [1:0]   req_ready_c;
  logic         grant;
`ifndef ALU_ARB_FIXED_PRIO_EN
  logic         last_q, last_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      sel_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      flags_q <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      sel_q   <= sel_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
      flags_q <= flags_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_q  <= last_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    sel_d       = sel_q;
    a_d         = a_q;
    b_d         = b_q;
    data_d      = data_q;
    flags_d     = flags_q;
    req_ready_c = 2'b00;
`ifdef ALU_ARB_FIXED_PRIO_EN
    grant       = ~bus.req_valid[0];
`else
    last_d      = last_q;
    // On a tie, serve the port that was not granted last time.
    grant       = (&bus.req_valid) ? ~last_q : ~bus.req_valid[0];
`endif

    case (state_q)
      S_IDLE: begin
        // No accept while in reset: the register update would be discarded.
        if ((|bus.req_valid) && !rst) begin
          req_ready_c[grant] = 1'b1;
          owner_d = grant;
          sel_d   = grant ? bus.req_sel1 : bus.req_sel0;
          a_d     = grant ? bus.req_a1   : bus.req_a0;
          b_d     = grant ? bus.req_b1   : bus.req_b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
          last_d  = grant;
`endif
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        data_d  = alu_out;
        flags_d = {alu_cf, alu_zf, alu_vf, alu_sf};
        state_d = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready[owner_q]) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = (state_q == S_RESP) ? (2'b01 << owner_q) : 2'b00;
  assign bus.rsp_data  = data_q;
  assign bus.rsp_flags = flags_q;
  assign alu_sel       = sel_q;
  assign alu_a         = a_q;
  assign alu_b         = b_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter; the bench supplies a behavioural ALU.
// Expected grant order follows ALU_ARB_FIXED_PRIO_EN when that macro is defined.
module tb_alu_arbiter;
  localparam int N = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_arb_if #(.n(N)) bus ();

  logic [3:0]   alu_sel;
  logic [N-1:0] alu_a, alu_b, alu_out;
  logic         alu_cf, alu_zf, alu_vf, alu_sf;
  logic [N:0]   alu_t;

  int checks = 0;
  int errors = 0;

  alu_arbiter #(.n(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .alu_sel (alu_sel),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_out (alu_out),
    .alu_cf  (alu_cf),
    .alu_zf  (alu_zf),
    .alu_vf  (alu_vf),
    .alu_sf  (alu_sf)
  );

  // Behavioural ALU: 0 and, 1 or, 2 xor, 3 add, 4 sub (cf = no borrow), 12 sra, others 0
  always_comb begin
    alu_t   = '0;
    alu_out = '0;
    alu_cf  = 1'b0;
    alu_vf  = 1'b0;
    case (alu_sel)
      4'd0: alu_out = alu_a & alu_b;
      4'd1: alu_out = alu_a | alu_b;
      4'd2: alu_out = alu_a ^ alu_b;
      4'd3: begin
        alu_t   = {1'b0, alu_a} + {1'b0, alu_b};
        alu_out = alu_t[N-1:0];
        alu_cf  = alu_t[N];
        alu_vf  = (alu_a[N-1] == alu_b[N-1]) && (alu_out[N-1] != alu_a[N-1]);
      end
      4'd4: begin
        alu_out = alu_a - alu_b;
        alu_cf  = (alu_a >= alu_b);
        alu_vf  = (alu_a[N-1] != alu_b[N-1]) && (alu_out[N-1] != alu_a[N-1]);
      end
      4'd12: alu_out = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      default: alu_out = '0;
    endcase
    alu_zf = (alu_out == '0);
    alu_sf = alu_out[N-1];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    bus.req_valid = 2'b00;
    bus.req_sel0  = '0;
    bus.req_sel1  = '0;
    bus.req_a0    = '0;
    bus.req_a1    = '0;
    bus.req_b0    = '0;
    bus.req_b1    = '0;
    bus.rsp_ready = 2'b11;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Raise a request on port p and hold it until accepted (bounded); returns with the op in EXEC.
  task automatic send_req(input int p, input logic [3:0] sel, input logic [N-1:0] a,
                          input logic [N-1:0] b, output bit ok);
    @(negedge clk);
    if (p == 0) begin
      bus.req_sel0 = sel; bus.req_a0 = a; bus.req_b0 = b;
    end else begin
      bus.req_sel1 = sel; bus.req_a1 = a; bus.req_b1 = b;
    end
    bus.req_valid[p] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if (bus.req_ready[p]) ok = 1'b1;
      else @(negedge clk);
    end
    @(posedge clk);
    #1 bus.req_valid[p] = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    bus.req_valid = 2'b11;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 2'b00) begin
      errors++; $display("FAIL reset_req_ready: got %b want 00", bus.req_ready);
    end
    checks++;
    if (bus.rsp_valid !== 2'b00) begin
      errors++; $display("FAIL reset_rsp_valid: got %b want 00", bus.rsp_valid);
    end
    checks++;
    if ({bus.rsp_data, bus.rsp_flags} !== '0) begin
      errors++; $display("FAIL reset_rsp_data: got %h/%b want 0/0", bus.rsp_data, bus.rsp_flags);
    end
    checks++;
    if ({alu_sel, alu_a, alu_b} !== '0) begin
      errors++; $display("FAIL reset_alu_regs: got sel=%0d a=%h b=%h want 0", alu_sel, alu_a, alu_b);
    end
    bus.req_valid = 2'b00;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_add();
    bit ok;
    send_req(0, 4'd3, 32'd5, 32'd7, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL add_grant: got no req_ready want grant"); end
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 2'b00 || alu_sel !== 4'd3 || alu_a !== 32'd5 || alu_b !== 32'd7) begin
      errors++;
      $display("FAIL add_exec: got rsp_valid=%b sel=%0d a=%0d b=%0d want 00/3/5/7",
               bus.rsp_valid, alu_sel, alu_a, alu_b);
    end
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 2'b01 || bus.rsp_data !== 32'd12 || bus.rsp_flags !== 4'b0000) begin
      errors++;
      $display("FAIL add_resp: got v=%b d=%0d f=%b want 01/12/0000",
               bus.rsp_valid, bus.rsp_data, bus.rsp_flags);
    end
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 2'b00) begin
      errors++; $display("FAIL add_release: got rsp_valid=%b want 00", bus.rsp_valid);
    end
  endtask

  task automatic test_sub();
    bit ok;
    send_req(1, 4'd4, 32'd3, 32'd3, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL sub_grant: got no req_ready want grant"); end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 2'b10 || bus.rsp_data !== 32'd0 || bus.rsp_flags !== 4'b1100) begin
      errors++;
      $display("FAIL sub_resp: got v=%b d=%0d f=%b want 10/0/1100",
               bus.rsp_valid, bus.rsp_data, bus.rsp_flags);
    end
  endtask

  task automatic test_sra_and_unused_op();
    bit ok;
    send_req(1, 4'd12, 32'h8000_0000, 32'd4, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL sra_grant: got no req_ready want grant"); end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 2'b10 || bus.rsp_data !== 32'hF800_0000 || bus.rsp_flags !== 4'b0001) begin
      errors++;
      $display("FAIL sra_resp: got v=%b d=%h f=%b want 10/f8000000/0001",
               bus.rsp_valid, bus.rsp_data, bus.rsp_flags);
    end
    send_req(1, 4'd15, 32'h1234_5678, 32'h9ABC_DEF0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL op15_grant: got no req_ready want grant"); end
    @(negedge clk);
    checks++;
    if (alu_sel !== 4'd15 || alu_a !== 32'h1234_5678) begin
      errors++; $display("FAIL op15_forward: got sel=%0d a=%h want 15/12345678", alu_sel, alu_a);
    end
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 2'b10 || bus.rsp_data !== 32'd0 || bus.rsp_flags !== 4'b0100) begin
      errors++;
      $display("FAIL op15_resp: got v=%b d=%h f=%b want 10/0/0100",
               bus.rsp_valid, bus.rsp_data, bus.rsp_flags);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    bus.rsp_ready = 2'b10;
    send_req(0, 4'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_grant: got no req_ready want grant"); end
    bus.req_sel1 = 4'd3; bus.req_a1 = 32'd1; bus.req_b1 = 32'd1;
    bus.req_valid[1] = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 2'b00) begin
      errors++; $display("FAIL bp_exec_ready: got %b want 00", bus.req_ready);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 2'b01 || bus.rsp_data !== 32'hF000_F000 ||
          bus.rsp_flags !== 4'b0001 || bus.req_ready !== 2'b00) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got v=%b d=%h f=%b rdy=%b want 01/f000f000/0001/00",
                 c, bus.rsp_valid, bus.rsp_data, bus.rsp_flags, bus.req_ready);
      end
    end
    bus.rsp_ready = 2'b11;
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 2'b00 || bus.req_ready !== 2'b10) begin
      errors++;
      $display("FAIL bp_release: got v=%b rdy=%b want 00/10", bus.rsp_valid, bus.req_ready);
    end
    @(posedge clk);
    #1 bus.req_valid[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 2'b10 || bus.rsp_data !== 32'd2) begin
      errors++;
      $display("FAIL bp_next_op: got v=%b d=%0d want 10/2", bus.rsp_valid, bus.rsp_data);
    end
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int         n_grants;
    logic [1:0] exp_g;
    logic [N-1:0] exp_d;
    idle_inputs();
    apply_reset();
    bus.req_sel0 = 4'd3; bus.req_a0 = 32'd1; bus.req_b0 = 32'd1;
    bus.req_sel1 = 4'd3; bus.req_a1 = 32'd2; bus.req_b1 = 32'd2;
    bus.req_valid = 2'b11;
    n_grants = 0;
    for (int c = 0; c < 40 && n_grants < 4; c++) begin
      @(negedge clk);
      if (bus.req_ready !== 2'b00) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp_g = 2'b01;
`else
        exp_g = (n_grants % 2 == 0) ? 2'b01 : 2'b10;
`endif
        checks++;
        if (bus.req_ready !== exp_g) begin
          errors++;
          $display("FAIL rr_grant[%0d]: got %b want %b", n_grants, bus.req_ready, exp_g);
        end
        n_grants++;
      end
      if (bus.rsp_valid !== 2'b00) begin
        exp_d = (bus.rsp_valid == 2'b01) ? 32'd2 : 32'd4;
        checks++;
        if (bus.rsp_data !== exp_d) begin
          errors++;
          $display("FAIL rr_data: got %0d want %0d for rsp_valid=%b", bus.rsp_data, exp_d, bus.rsp_valid);
        end
      end
    end
    checks++;
    if (n_grants != 4) begin
      errors++; $display("FAIL rr_grant_count: got %0d want 4", n_grants);
    end
    bus.req_valid = 2'b00;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_in_exec();
    bit ok;
    send_req(0, 4'd3, 32'd9, 32'd9, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rst_exec_grant: got no req_ready want grant"); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 2'b00 || bus.req_ready !== 2'b00) begin
      errors++;
      $display("FAIL rst_exec_out: got v=%b rdy=%b want 00/00", bus.rsp_valid, bus.req_ready);
    end
    checks++;
    if ({bus.rsp_data, bus.rsp_flags, alu_sel, alu_a, alu_b} !== '0) begin
      errors++;
      $display("FAIL rst_exec_regs: got d=%h f=%b sel=%0d a=%h b=%h want all 0",
               bus.rsp_data, bus.rsp_flags, alu_sel, alu_a, alu_b);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 2'b00) begin
        errors++; $display("FAIL rst_exec_no_rsp[%0d]: got %b want 00", c, bus.rsp_valid);
      end
    end
    bus.req_valid = 2'b11;
    #1;
    checks++;
    if (bus.req_ready !== 2'b01) begin
      errors++; $display("FAIL rst_exec_tie: got %b want 01", bus.req_ready);
    end
    @(posedge clk);
    #1 bus.req_valid = 2'b00;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_add();
    test_sub();
    test_sra_and_unused_op();
    test_backpressure();
    test_round_robin();
    test_reset_in_exec();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
